puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
Measurement controller for the ring-oscillator PUF. It drives challenge pairs into the two oscillator/mux/counter banks and gates the oscillators for a fixed counting window. It then reads back both frozen counts, magnitude-compares them, and assembles a RESP_BITS-wide response word. It sits between the host interface (start/base challenge) and the two counter banks, and replaces free-running counting with a deterministic, clock-timed evaluation.

Parameters:
CW, 16, width of each bank counter value
RESP_BITS, 8, number of response bits produced per run (1..16)
WINDOW_CYCLES, 1024, clk cycles per bit with ro_ena high (>=1)
CLEAR_CYCLES, 2, clk cycles per bit with cnt_clr high before the window (>=1)
SETTLE_CYCLES, 4, clk cycles per bit after the window before counts are sampled (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-high (codebase name kept; asserted = 1)
start  input  1  begin a run; sampled only in IDLE
chal_base  input  4  base challenge for the run, latched on accepted start
count_a  input  CW  bank A counter value
count_b  input  CW  bank B counter value
ro_ena  output  1  oscillator enable to both banks
cnt_clr  output  1  counter clear to both banks
chal_a  output  4  bank A mux select
chal_b  output  4  bank B mux select
busy  output  1  high from the cycle after an accepted start through DONE
resp_valid  output  1  one-cycle pulse when response is complete
response  output  RESP_BITS  assembled response word

Behaviour:
- Reset (rst_n=1 at posedge): state=IDLE; ro_ena=0, cnt_clr=0, chal_a=0, chal_b=1, busy=0, resp_valid=0, response=0; bit index k=0. Reset mid-run aborts immediately to these values.
- FSM states: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE. All outputs are registered.
- IDLE: on start=1, latch base=chal_base, clear response to 0, set k=0, go to CLEAR. start while not IDLE is ignored.
- Challenge per bit k: chal_a = (base + k) mod 16; chal_b = (base + k + 1) mod 16. The two selects always differ, and wrap-around from 15 to 0 is required. Selects are stable in all states from CLEAR through COMPARE.
- CLEAR: cnt_clr=1, ro_ena=0 for exactly CLEAR_CYCLES cycles, then RUN.
- RUN: cnt_clr=0, ro_ena=1 for exactly WINDOW_CYCLES cycles, then SETTLE.
- SETTLE: ro_ena=0, cnt_clr=0 for exactly SETTLE_CYCLES cycles; counts are frozen and settled. Then COMPARE.
- COMPARE (1 cycle): response[k] = (count_a > count_b), a full unsigned CW-bit magnitude compare. Equal counts give 0. If k==RESP_BITS-1 go to DONE, else k=k+1 and go to CLEAR.
- DONE (1 cycle): resp_valid=1, busy=1; next IDLE with busy=0.
- response holds its value after DONE until the next accepted start or reset.
- Latency: per-bit period P = CLEAR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+1. resp_valid asserts RESP_BITS*P+1 cycles after the edge that accepts start.
- A start held high in the cycle DONE returns to IDLE is accepted on the following IDLE cycle.
- Internal cycle counter is wide enough for max(WINDOW_CYCLES, CLEAR_CYCLES, SETTLE_CYCLES). No overflow is permitted.

Optional Feature:
PUF_TIE_FLAG_EN
- Defined: extra output tie_mask [RESP_BITS-1:0], reset 0 and cleared on accepted start. In COMPARE, tie_mask[k] = (count_a == count_b). tie_mask holds until the next start or reset, alongside response.
- Undefined: the port is absent. Ties silently produce response bit 0.

Test Plan:
Params WINDOW=16, CLEAR=2, SETTLE=4, RESP_BITS=4 (P=23) for all tests below.
1. Reset: rst_n=1 for 2 cycles mid-RUN -> next cycle ro_ena=0, busy=0, response=0, chal_a=0, chal_b=1, state IDLE.
2. Basic run: chal_base=3, bench count_a=200/count_b=100 for bits 0,2 and 50/90 for bits 1,3 -> response=4'b0101; resp_valid is a single pulse exactly 93 cycles after start is accepted.
3. Wrap: chal_base=14 -> (chal_a,chal_b) per bit = (14,15),(15,0),(0,1),(1,2).
4. Timing: count cnt_clr-high and ro_ena-high cycles per bit -> exactly 2 and 16. Check they are never both high, and there is a 4-cycle gap before each COMPARE.
5. Tie and edge values: count_a=count_b=16'hFFFF -> bit 0 (tie_mask bit 1 with PUF_TIE_FLAG_EN). count_a=16'h8000, count_b=16'h7FFF -> bit 1.
6. Start while busy: pulse start at cycle 10 and 40 of a run -> no restart. chal_base changes are ignored; completion occurs at cycle 93 as in test 2.

Source files
------------

// File: rtl/puf_challenge_sequencer_if.sv
// Host and counter-bank signal bundle for puf_challenge_sequencer.
// The tie_mask signal is present only when PUF_TIE_FLAG_EN is defined.
interface puf_challenge_sequencer_if #(
  parameter int CW        = 16,
  parameter int RESP_BITS = 8
);
  logic                 start;
  logic [3:0]           chal_base;
  logic [CW-1:0]        count_a;
  logic [CW-1:0]        count_b;
  logic                 ro_ena;
  logic                 cnt_clr;
  logic [3:0]           chal_a;
  logic [3:0]           chal_b;
  logic                 busy;
  logic                 resp_valid;
  logic [RESP_BITS-1:0] response;
`ifdef PUF_TIE_FLAG_EN
  logic [RESP_BITS-1:0] tie_mask;
`endif

  modport slave (
    input  start, chal_base, count_a, count_b,
    output ro_ena, cnt_clr, chal_a, chal_b, busy, resp_valid, response
`ifdef PUF_TIE_FLAG_EN
    , output tie_mask
`endif
  );

  modport master (
    output start, chal_base, count_a, count_b,
    input  ro_ena, cnt_clr, chal_a, chal_b, busy, resp_valid, response
`ifdef PUF_TIE_FLAG_EN
    , input tie_mask
`endif
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF measurement controller: clear, count window, settle, compare per bit.
// Optional PUF_TIE_FLAG_EN adds a tie_mask output flagging equal counts.
module puf_challenge_sequencer #(
  parameter int CW            = 16,
  parameter int RESP_BITS     = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  puf_challenge_sequencer_if.slave  bus
);
  localparam int MAX_A = (WINDOW_CYCLES > CLEAR_CYCLES) ? WINDOW_CYCLES : CLEAR_CYCLES;
  localparam int MAXC  = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int KW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic [3:0]           base_q, base_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [3:0]           chal_a_d;
  logic                 ro_ena_q, cnt_clr_q, busy_q, resp_valid_q;
  logic [3:0]           chal_a_q, chal_b_q;
`ifdef PUF_TIE_FLAG_EN
  logic [RESP_BITS-1:0] tie_q, tie_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    k_d     = k_q;
    base_d  = base_q;
    resp_d  = resp_q;
`ifdef PUF_TIE_FLAG_EN
    tie_d   = tie_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          base_d  = bus.chal_base;
          resp_d  = '0;
`ifdef PUF_TIE_FLAG_EN
          tie_d   = '0;
`endif
          k_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (cnt_q == CNT_W'(WINDOW_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = COMPARE;
      end
      COMPARE: begin
        cnt_d       = '0;
        resp_d[k_q] = (bus.count_a > bus.count_b);
`ifdef PUF_TIE_FLAG_EN
        tie_d[k_q]  = (bus.count_a == bus.count_b);
`endif
        if (k_q == KW'(RESP_BITS - 1)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = CLEAR;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Selects track the next bit index so they are valid from the first CLEAR cycle.
    chal_a_d = base_d + 4'(k_d);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      base_q       <= '0;
      resp_q       <= '0;
      ro_ena_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      chal_a_q     <= 4'd0;
      chal_b_q     <= 4'd1;
`ifdef PUF_TIE_FLAG_EN
      tie_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      base_q       <= base_d;
      resp_q       <= resp_d;
      ro_ena_q     <= (state_d == RUN);
      cnt_clr_q    <= (state_d == CLEAR);
      busy_q       <= (state_d != IDLE);
      resp_valid_q <= (state_d == DONE);
      chal_a_q     <= chal_a_d;
      chal_b_q     <= chal_a_d + 4'd1;
`ifdef PUF_TIE_FLAG_EN
      tie_q        <= tie_d;
`endif
    end
  end

  assign bus.ro_ena     = ro_ena_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.chal_a     = chal_a_q;
  assign bus.chal_b     = chal_b_q;
  assign bus.response   = resp_q;
`ifdef PUF_TIE_FLAG_EN
  assign bus.tie_mask   = tie_q;
`endif
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with WINDOW=16, CLEAR=2, SETTLE=4, RESP_BITS=4.
module tb_puf_challenge_sequencer;
  localparam int P = 23;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  puf_challenge_sequencer_if #(.CW(16), .RESP_BITS(4)) bus ();

  puf_challenge_sequencer #(
    .CW(16), .RESP_BITS(4), .WINDOW_CYCLES(16), .CLEAR_CYCLES(2), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tbl_a [4];
  logic [15:0] tbl_b [4];
  int          clr_cnt [4];
  int          ro_cnt  [4];
  int          gap_obs [4];
  logic [3:0]  obs_a [4];
  logic [3:0]  obs_b [4];
  logic        busy_tr [200];
  int          lat, pulses, overlap, stab_err, last_ro;
  logic [3:0]  resp_first;
  logic [3:0]  ref_a, ref_b;

  // Runs one measurement from IDLE and records observations at each negedge j after
  // the accepting edge. Latency is counted in rising edges until resp_valid is captured.
  task automatic do_run(input logic [3:0] base, input int sp1, input int sp2);
    int b;
    @(negedge clk);
    bus.chal_base = base;
    bus.start     = 1'b1;
    bus.count_a   = tbl_a[0];
    bus.count_b   = tbl_b[0];
    lat = -1; pulses = 0; overlap = 0; stab_err = 0; last_ro = -1;
    resp_first = 'x;
    for (int i = 0; i < 4; i++) begin
      clr_cnt[i] = 0; ro_cnt[i] = 0; gap_obs[i] = -1;
    end
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      b = (j / P > 3) ? 3 : j / P;
      bus.count_a   = tbl_a[b];
      bus.count_b   = tbl_b[b];
      bus.start     = (j == sp1) || (j == sp2);
      bus.chal_base = ~base;
      busy_tr[j]    = bus.busy;
      if (j < 4 * P) begin
        if (bus.cnt_clr) clr_cnt[b]++;
        if (bus.ro_ena) begin ro_cnt[b]++; last_ro = j; end
        if (bus.cnt_clr && bus.ro_ena) overlap++;
        if (j % P == 0) begin ref_a = bus.chal_a; ref_b = bus.chal_b; end
        else if (bus.chal_a !== ref_a || bus.chal_b !== ref_b) stab_err++;
        if (j % P == P - 1) begin
          obs_a[b]   = bus.chal_a;
          obs_b[b]   = bus.chal_b;
          gap_obs[b] = j - last_ro - 1;
        end
      end
      if (bus.resp_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin lat = j + 1; resp_first = bus.response; end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.ro_ena, bus.cnt_clr, bus.busy, bus.resp_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.ro_ena, bus.cnt_clr, bus.busy, bus.resp_valid});
    end
    n_tests++;
    if (bus.chal_a !== 4'd0 || bus.chal_b !== 4'd1) begin
      n_fail++; $display("FAIL reset_chal: got %0d/%0d want 0/1", bus.chal_a, bus.chal_b);
    end
    n_tests++;
    if (bus.response !== 4'd0) begin
      n_fail++; $display("FAIL reset_resp: got %b want 0000", bus.response);
    end
`ifdef PUF_TIE_FLAG_EN
    n_tests++;
    if (bus.tie_mask !== 4'd0) begin
      n_fail++; $display("FAIL reset_tie: got %b want 0000", bus.tie_mask);
    end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic_run;
    tbl_a = '{16'd200, 16'd50, 16'd200, 16'd50};
    tbl_b = '{16'd100, 16'd90, 16'd100, 16'd90};
    do_run(4'd3, -1, -1);
    n_tests++;
    if (resp_first !== 4'b0101) begin
      n_fail++; $display("FAIL basic_resp: got %b want 0101", resp_first);
    end
    n_tests++;
    if (lat !== 93) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 93", lat);
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL basic_pulses: got %0d want 1", pulses);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs_a[i] !== 4'(3 + i) || obs_b[i] !== 4'(4 + i)) begin
        n_fail++; $display("FAIL basic_chal%0d: got %0d/%0d want %0d/%0d", i, obs_a[i], obs_b[i], 3 + i, 4 + i);
      end
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.response !== 4'b0101) begin
      n_fail++; $display("FAIL basic_hold: busy=%b resp=%b want 0/0101", bus.busy, bus.response);
    end
    n_tests++;
    if (stab_err !== 0) begin
      n_fail++; $display("FAIL basic_chal_stable: got %0d changes want 0", stab_err);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    bus.chal_base = 4'd7;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (bus.ro_ena !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: ro_ena got %b want 1", bus.ro_ena);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    n_tests++;
    if ({bus.ro_ena, bus.cnt_clr, bus.busy, bus.resp_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_ctrl: got %b want 0000", {bus.ro_ena, bus.cnt_clr, bus.busy, bus.resp_valid});
    end
    n_tests++;
    if (bus.response !== 4'd0 || bus.chal_a !== 4'd0 || bus.chal_b !== 4'd1) begin
      n_fail++; $display("FAIL midrst_vals: resp=%b chal=%0d/%0d want 0000 0/1", bus.response, bus.chal_a, bus.chal_b);
    end
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: busy=%b cnt_clr=%b want 0/0", bus.busy, bus.cnt_clr);
    end
  endtask

  task automatic test_wrap;
    do_run(4'd14, -1, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs_a[i] !== 4'(14 + i) || obs_b[i] !== 4'(15 + i)) begin
        n_fail++; $display("FAIL wrap_chal%0d: got %0d/%0d want %0d/%0d", i, obs_a[i], obs_b[i], (14 + i) % 16, (15 + i) % 16);
      end
    end
  endtask

  task automatic test_timing;
    do_run(4'd9, -1, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (clr_cnt[i] !== 2 || ro_cnt[i] !== 16) begin
        n_fail++; $display("FAIL timing_bit%0d: clr=%0d ro=%0d want 2/16", i, clr_cnt[i], ro_cnt[i]);
      end
      n_tests++;
      if (gap_obs[i] !== 4) begin
        n_fail++; $display("FAIL timing_gap%0d: got %0d want 4", i, gap_obs[i]);
      end
    end
    n_tests++;
    if (overlap !== 0) begin
      n_fail++; $display("FAIL timing_overlap: got %0d want 0", overlap);
    end
  endtask

  task automatic test_tie_edge;
    tbl_a = '{16'hFFFF, 16'h8000, 16'h0000, 16'h1234};
    tbl_b = '{16'hFFFF, 16'h7FFF, 16'h0001, 16'h1234};
    do_run(4'd0, -1, -1);
    n_tests++;
    if (resp_first !== 4'b0010) begin
      n_fail++; $display("FAIL tie_resp: got %b want 0010", resp_first);
    end
`ifdef PUF_TIE_FLAG_EN
    n_tests++;
    if (bus.tie_mask !== 4'b1001) begin
      n_fail++; $display("FAIL tie_mask: got %b want 1001", bus.tie_mask);
    end
`endif
  endtask

  task automatic test_start_busy;
    tbl_a = '{16'd200, 16'd50, 16'd200, 16'd50};
    tbl_b = '{16'd100, 16'd90, 16'd100, 16'd90};
    do_run(4'd5, 10, 40);
    n_tests++;
    if (lat !== 93 || pulses !== 1) begin
      n_fail++; $display("FAIL busy_start_latency: lat=%0d pulses=%0d want 93/1", lat, pulses);
    end
    n_tests++;
    if (obs_a[3] !== 4'd8 || obs_b[3] !== 4'd9) begin
      n_fail++; $display("FAIL busy_start_base: got %0d/%0d want 8/9", obs_a[3], obs_b[3]);
    end
    n_tests++;
    if (resp_first !== 4'b0101 || busy_tr[93] !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_resp: resp=%b busy93=%b want 0101/0", resp_first, busy_tr[93]);
    end
  endtask

  task automatic test_back_to_back;
    do_run(4'd2, 92, 93);
    n_tests++;
    if (busy_tr[92] !== 1'b1 || busy_tr[93] !== 1'b0 || busy_tr[94] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy: got %b%b%b want 101", busy_tr[92], busy_tr[93], busy_tr[94]);
    end
    n_tests++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.chal_base = 4'd0;
    bus.count_a   = '0;
    bus.count_b   = '0;
    test_reset();
    test_basic_run();
    test_reset_mid_run();
    test_wrap();
    test_timing();
    test_tie_edge();
    test_start_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
